// File: rtl/bitstream_streamer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_stream_if : AXI-stream beat bundle (tvalid/tready/tdata/tlast)          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface axi_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/bitstream_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bitstream_streamer : serial bitstream -> AXI-stream words via small FIFO    |
// | Optional cfg pulse: BITSTREAM_STREAMER_CFG_PULSE_EN. Rev 1.0                |
// +----------------------------------------------------------------------------+
module bitstream_streamer #(
  parameter int BITSTREAM_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH           = 4,
  parameter int LEN_WIDTH            = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic [LEN_WIDTH-1:0] load_len,
  input  logic                 ser_valid,
  input  logic                 ser_bit,
  output logic                 ser_ready,
  output logic                 cfg,
  output logic                 busy,
  output logic                 done,
  axi_stream_if.master         cfg_bitstream
);
  localparam int c_w   = BITSTREAM_DATA_WIDTH;
  localparam int c_aw  = $clog2(FIFO_DEPTH);
  localparam int c_bcw = (c_w > 1) ? $clog2(c_w) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state, w_next_state;
  logic [LEN_WIDTH-1:0] r_len, r_word_cnt;
  logic [c_bcw-1:0]     r_bit_cnt;
  logic [c_w-2:0]       r_shift;
  logic [c_w:0]         r_mem [FIFO_DEPTH];
  logic [c_aw:0]        r_wr_ptr, r_rd_ptr;

  logic                 w_full, w_empty, w_accept, w_push, w_pop;
  logic                 w_word_last, w_load_ok;
  logic [c_w-1:0]       w_shift_next;
  logic [c_w:0]         w_head;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                        (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_load_ok    = (r_state == S_IDLE) && load_start && (load_len != '0);
  assign ser_ready    = (r_state == S_SHIFT) && !w_full;
  assign w_accept     = ser_valid && ser_ready;
  assign w_shift_next = {r_shift, ser_bit};
  assign w_push       = w_accept && (r_bit_cnt == c_bcw'(c_w - 1));
  assign w_word_last  = (r_word_cnt == (r_len - LEN_WIDTH'(1)));
  assign w_head       = r_mem[r_rd_ptr[c_aw-1:0]];

  assign cfg_bitstream.tvalid = ((r_state == S_SHIFT) || (r_state == S_DRAIN)) && !w_empty;
  assign cfg_bitstream.tdata  = w_head[c_w-1:0];
  assign cfg_bitstream.tlast  = w_head[c_w];
  assign w_pop = cfg_bitstream.tvalid && cfg_bitstream.tready;

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

`ifdef BITSTREAM_STREAMER_CFG_PULSE_EN
  assign cfg = (r_state == S_START);
`else
  assign cfg = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load_ok) begin
        r_len      <= load_len;
        r_word_cnt <= '0;
        r_bit_cnt  <= '0;
      end
      if (w_accept) begin
        r_shift   <= w_shift_next[c_w-2:0];
        r_bit_cnt <= w_push ? '0 : r_bit_cnt + c_bcw'(1);
      end
      if (w_push) begin
        r_word_cnt <= r_word_cnt + LEN_WIDTH'(1);
        r_wr_ptr   <= r_wr_ptr + (c_aw + 1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (c_aw + 1)'(1);
      end
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= {w_word_last, w_shift_next};
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_load_ok) w_next_state = S_START;
      S_START: w_next_state = S_SHIFT;
      S_SHIFT: if (w_push && w_word_last) w_next_state = S_DRAIN;
      S_DRAIN: if (w_pop && w_head[c_w]) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_bitstream_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bitstream_streamer : directed table-driven bench for bitstream_streamer  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_bitstream_streamer;
`ifdef BITSTREAM_STREAMER_CFG_PULSE_EN
  localparam logic EXP_CFG = 1'b1;
`else
  localparam logic EXP_CFG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start;
  logic [7:0] load_len;
  logic       ser_valid;
  logic       ser_bit;
  logic       ser_ready;
  logic       cfg;
  logic       busy;
  logic       done;

  axi_stream_if #(.DATA_WIDTH(8)) axis ();

  bitstream_streamer #(
    .BITSTREAM_DATA_WIDTH(8),
    .FIFO_DEPTH(4),
    .LEN_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .ser_valid(ser_valid), .ser_bit(ser_bit), .ser_ready(ser_ready),
    .cfg(cfg), .busy(busy), .done(done), .cfg_bitstream(axis)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              len;
    logic [5:0][7:0] w;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cfg_cnt  = 0;
  int         loads    = 0;
  logic [7:0] q_data[$];
  logic       q_last[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beat collector and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("stall_tvalid", axis.tvalid, 1'b1);
        check("stall_tdata", axis.tdata, prev_data);
        check("stall_tlast", axis.tlast, prev_last);
      end
      if (axis.tvalid && axis.tready) begin
        q_data.push_back(axis.tdata);
        q_last.push_back(axis.tlast);
      end
      if (cfg) cfg_cnt++;
    end
    prev_stall = !rst && axis.tvalid && !axis.tready;
    prev_data  = axis.tdata;
    prev_last  = axis.tlast;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int len);
    load_start = 1'b1;
    load_len   = 8'(len);
    tick();
    load_start = 1'b0;
    loads++;
    @(negedge clk);
    check("cfg_in_start", cfg, EXP_CFG);
    check("busy_in_start", busy, 1'b1);
    tick();
  endtask

  task automatic send_bits(input logic [7:0] w, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      int   t = 0;
      logic acc;
      ser_valid = 1'b1;
      ser_bit   = w[i];
      forever begin
        @(negedge clk);
        acc = ser_ready;
        tick();
        if (acc) break;
        t++;
        if (t > 200) begin
          n_checks++;
          n_fail++;
          $display("FAIL ser_ready_timeout: got stalled expected accept at %0t", $time);
          ser_valid = 1'b0;
          return;
        end
      end
    end
    ser_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    @(negedge clk);
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got done=0 expected done=1 at %0t", $time);
    end else begin
      check("busy_in_done", busy, 1'b1);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
      check("busy_after_done", busy, 1'b0);
      check("tvalid_idle", axis.tvalid, 1'b0);
    end
    tick();
  endtask

  task automatic check_beats(input int n, input logic [5:0][7:0] w);
    check("beat_count", q_data.size(), n);
    for (int i = 0; i < n && i < q_data.size(); i++) begin
      check($sformatf("beat%0d_data", i), q_data[i], w[i]);
      check($sformatf("beat%0d_last", i), q_last[i], (i == n - 1));
    end
  endtask

  task automatic run_load(input vec_t v);
    q_data.delete();
    q_last.delete();
    start_load(v.len);
    for (int i = 0; i < v.len; i++) send_bits(v.w[i], 8);
    wait_done();
    check_beats(v.len, v.w);
  endtask

  vec_t            tbl[4];
  vec_t            v1;
  logic [5:0][7:0] wb;

  initial begin
    tbl[0].len = 2; tbl[0].w = '0; tbl[0].w[0] = 8'hA5; tbl[0].w[1] = 8'h3C;
    tbl[1].len = 1; tbl[1].w = '0; tbl[1].w[0] = 8'h81;
    tbl[2].len = 4; tbl[2].w = '0; tbl[2].w[0] = 8'h00; tbl[2].w[1] = 8'hFF;
                    tbl[2].w[2] = 8'h7E; tbl[2].w[3] = 8'h12;
    tbl[3].len = 3; tbl[3].w = '0; tbl[3].w[0] = 8'h01; tbl[3].w[1] = 8'h80;
                    tbl[3].w[2] = 8'h55;

    rst = 1'b1; load_start = 1'b0; load_len = '0;
    ser_valid = 1'b0; ser_bit = 1'b0; axis.tready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_tvalid", axis.tvalid, 1'b0);
    check("rst_ser_ready", ser_ready, 1'b0);
    check("rst_cfg", cfg, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    for (int k = 0; k < 4; k++) run_load(tbl[k]);

    // Backpressure: FIFO fills after 4 words, then drains in order.
    wb = '0;
    for (int i = 0; i < 6; i++) wb[i] = 8'(8'h11 * (i + 1));
    q_data.delete(); q_last.delete();
    axis.tready = 1'b0;
    start_load(6);
    for (int i = 0; i < 4; i++) send_bits(wb[i], 8);
    @(negedge clk);
    check("full_ser_ready", ser_ready, 1'b0);
    check("full_tvalid", axis.tvalid, 1'b1);
    check("full_head", axis.tdata, 8'h11);
    check("full_no_beats", q_data.size(), 0);
    repeat (3) tick();
    axis.tready = 1'b1;
    for (int i = 4; i < 6; i++) send_bits(wb[i], 8);
    wait_done();
    check_beats(6, wb);

    // Zero-length and mid-load start requests are ignored.
    load_start = 1'b1; load_len = 8'd0;
    tick();
    load_start = 1'b0;
    @(negedge clk);
    check("len0_busy", busy, 1'b0);
    check("len0_tvalid", axis.tvalid, 1'b0);
    tick();
    wb = '0; wb[0] = 8'h5A; wb[1] = 8'hC3;
    q_data.delete(); q_last.delete();
    start_load(2);
    send_bits(wb[0], 8);
    load_start = 1'b1; load_len = 8'd5;
    tick();
    load_start = 1'b0;
    @(negedge clk);
    check("restart_busy", busy, 1'b1);
    check("restart_ser_ready", ser_ready, 1'b1);
    tick();
    send_bits(wb[1], 8);
    wait_done();
    check_beats(2, wb);

    // Reset after 1.5 words aborts the load and flushes the FIFO.
    q_data.delete(); q_last.delete();
    axis.tready = 1'b0;
    start_load(4);
    send_bits(8'hDE, 8);
    send_bits(8'hAD, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_tvalid", axis.tvalid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_ser_ready", ser_ready, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_no_beats", q_data.size(), 0);
    tick();
    axis.tready = 1'b1;
    v1.len = 1; v1.w = '0; v1.w[0] = 8'hFF;
    run_load(v1);

    repeat (2) tick();
    check("cfg_pulse_total", cfg_cnt, EXP_CFG ? loads : 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/bitstream_streamer.md
BITSTREAM_STREAMER -- requirements
Module: bitstream_streamer

Interface
REQ-001 SHALL have parameter BITSTREAM_DATA_WIDTH, default 8: bits per AXI-stream beat.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output buffer depth in words; a power of 2 and at least 2.
REQ-003 SHALL have parameter LEN_WIDTH, default 8: width of the word-count request.
REQ-004 SHALL have one clock; reset is synchronous and active-high. Ports: clk (input, 1, clock) and rst (input, 1, synchronous active-high reset).
REQ-005 load_start  input  1  request pulse to begin a bitstream load.
REQ-006 load_len  input  LEN_WIDTH  number of words in the load; sampled when load_start is accepted.
REQ-007 ser_valid  input  1  a serial bit is offered on ser_bit.
REQ-008 ser_bit  input  1  serial bitstream data, MSB of each word first.
REQ-009 ser_ready  output  1  block accepts a serial bit this cycle.
REQ-010 cfg  output  1  configuration-begin pulse to the fabric.
REQ-011 busy  output  1  a load is in progress.
REQ-012 done  output  1  one-cycle pulse when a load completes.
REQ-013 cfg_bitstream  axi_stream_if.master  tdata is BITSTREAM_DATA_WIDTH  carries tvalid, tready, tdata and tlast toward the configuration consumer.

Function
REQ-014 SHALL implement states IDLE, START, SHIFT, DRAIN and DONE.
REQ-015 IDLE -> START when load_start=1 and load_len!=0; the block SHALL capture load_len and clear the word counter.
REQ-016 load_start with load_len=0, or load_start in any state other than IDLE, SHALL be ignored.
REQ-017 START SHALL last exactly 1 cycle, then go to SHIFT.
REQ-018 ser_ready SHALL be 1 only in SHIFT while the FIFO is not full; a bit is accepted when ser_valid && ser_ready.
REQ-019 The bit counter SHALL pack accepted bits MSB first: the first bit lands in tdata[W-1].
REQ-020 On acceptance of the W-th bit, the block SHALL push the word into the FIFO in the same clock edge; tvalid SHALL rise the next cycle at the earliest.
REQ-021 Each FIFO entry SHALL store {last, data}; last=1 only for the word with index load_len-1.
REQ-022 After pushing the final word, the state SHALL go SHIFT -> DRAIN; ser_ready=0 in DRAIN, and further serial bits are ignored.
REQ-023 tvalid SHALL equal FIFO-not-empty in SHIFT and DRAIN, and 0 otherwise; tdata and tlast come from the FIFO head.
REQ-024 While tvalid && !tready, tvalid, tdata and tlast SHALL stay stable; a pop occurs only on tvalid && tready.
REQ-025 A simultaneous push and pop with the FIFO full or empty SHALL lose no data.
REQ-026 Exactly one tlast SHALL be emitted per load.
REQ-027 DRAIN -> DONE on the handshake of the tlast beat; DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-028 busy SHALL be 1 in START, SHIFT, DRAIN and DONE.
REQ-029 The FIFO pointers and the word counter SHALL wrap modulo their width without overflow hazards.

Reset
REQ-030 While rst=1 at a clk edge: state=IDLE, FIFO empty, counters=0.
REQ-031 During and after reset: tvalid=0, ser_ready=0, cfg=0, busy=0, done=0.
REQ-032 rst asserted mid-load SHALL abort the load, discard buffered words and emit no tlast.

Configuration
REQ-033 Macro BITSTREAM_STREAMER_CFG_PULSE_EN SHALL control the cfg pulse.
REQ-034 With the macro defined, cfg=1 for exactly the START cycle.
REQ-035 Without the macro, cfg SHALL be tied to 0 and all other behaviour is identical.

Verification
REQ-036 W=8, load_len=2, serial bits 0xA5 then 0x3C, tready=1 -> beats 0xA5 (tlast=0) and 0x3C (tlast=1), then done=1 for 1 cycle and busy=0 one cycle later.
REQ-037 W=8, FIFO_DEPTH=4, load_len=6, tready=0 -> ser_ready drops after 4 words are buffered; after tready=1 all 6 words arrive in order with tlast on the 6th.
REQ-038 load_start with load_len=0, and a second load_start during SHIFT -> both ignored; state and busy unchanged.
REQ-039 rst=1 after 1.5 words of a 4-word load -> next cycle tvalid=0, busy=0, ser_ready=0; a new load with load_len=1 and bits 0xFF -> a single beat 0xFF with tlast=1.
REQ-040 With the macro defined, cfg=1 for exactly 1 cycle, the cycle after load_start is accepted; without it, cfg stays 0 for the whole run.
